// File: rtl/blur_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blur_pkg
// Brief    : Shared types and constants for the 5x5 Gaussian blur datapath.
// Revision : 1.0 - initial release
// ============================================================================
package blur_pkg;

    localparam int KHEIGHT = 5;
    localparam int KWIDTH  = 5;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2
    } color_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } feeder_state_e;

    function automatic logic [7:0] color_byte(input rgb_t px, input color_e c);
        logic [7:0] v;
        v = px.b;
        case (c)
            RED:     v = px.r;
            GREEN:   v = px.g;
            default: v = px.b;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/blur_column_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : blur_column_feeder_if
// Brief    : Pixel-in / byte-out handshake bundle of the blur column feeder.
// Revision : 1.0 - initial release
// ============================================================================
interface blur_column_feeder_if;

    logic              i_valid;
    logic              o_ready;
    blur_pkg::rgb_t    i_pixel;
    logic              i_row_end;
    logic              i_frame_start;
    logic              o_valid;
    logic [7:0]        o_pixel;
    logic              o_row_end;

    modport master (
        output i_valid, i_pixel, i_row_end, i_frame_start,
        input  o_ready, o_valid, o_pixel, o_row_end
    );

    modport slave (
        input  i_valid, i_pixel, i_row_end, i_frame_start,
        output o_ready, o_valid, o_pixel, o_row_end
    );

endinterface
`default_nettype wire

// File: rtl/blur_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : blur_line_buffer
// Brief    : One image row of RGB pixels; async read, sync write, shared address.
// Revision : 1.0 - initial release
// ============================================================================
module blur_line_buffer
    import blur_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int COL_W     = $clog2(IMG_WIDTH)
) (
    input  wire logic             i_clk,
    input  wire logic             i_we,
    input  wire logic [COL_W-1:0] i_addr,
    input  wire rgb_t             i_wdata,
    output rgb_t                  o_rdata
);

    rgb_t r_mem [IMG_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/blur_column_feeder.sv
`default_nettype none
// ============================================================================
// Module   : blur_column_feeder
// Brief    : Turns raster RGB pixels into 5-row vertical columns, streamed as
//            15 bytes (oldest row first, R/G/B per pixel) per accepted pixel.
// Revision : 1.0 - initial release
// ============================================================================
module blur_column_feeder
    import blur_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int KHEIGHT   = 5,
    parameter int COL_W     = $clog2(IMG_WIDTH)
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst,
    blur_column_feeder_if.slave bus
);

    localparam int         c_nbuf      = KHEIGHT - 1;
    localparam logic [2:0] c_last_slot = 3'(KHEIGHT - 1);

    feeder_state_e    r_state, w_state_nxt;
    logic [2:0]       r_slot, w_slot_nxt;
    color_e           r_color, w_color_nxt;
    logic [COL_W-1:0] r_col;
    logic [2:0]       r_rows_filled;
    logic             r_row_end;
    rgb_t             r_column [KHEIGHT];

    logic             w_last_byte;
    logic             w_ready;
    logic             w_accept;
    logic [COL_W-1:0] w_col;
    logic [2:0]       w_rows;
    logic             w_wrap;
    logic [7:0]       w_byte;
    rgb_t             w_lb_rd [c_nbuf];
    rgb_t             w_lb_wr [c_nbuf];

    // A frame start overrides the running counters for this pixel only.
    assign w_col    = bus.i_frame_start ? '0 : r_col;
    assign w_rows   = bus.i_frame_start ? '0 : r_rows_filled;
    assign w_wrap   = bus.i_row_end || (w_col == COL_W'(IMG_WIDTH - 1));
    assign w_accept = bus.i_valid && w_ready;

    generate
        for (genvar k = 0; k < c_nbuf; k++) begin : g_lb
            if (k == c_nbuf - 1) begin : g_newest
                assign w_lb_wr[k] = bus.i_pixel;
            end else begin : g_shift
                assign w_lb_wr[k] = w_lb_rd[k+1];
            end
            blur_line_buffer #(
                .IMG_WIDTH (IMG_WIDTH),
                .COL_W     (COL_W)
            ) u_lb (
                .i_clk   (i_clk),
                .i_we    (w_accept),
                .i_addr  (w_col),
                .i_wdata (w_lb_wr[k]),
                .o_rdata (w_lb_rd[k])
            );
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_slot  <= '0;
            r_color <= RED;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
            r_color <= w_color_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_color_nxt = r_color;
        w_last_byte = (r_slot == c_last_slot) && (r_color == BLUE);
        w_ready     = (r_state == IDLE) || w_last_byte;
        case (r_state)
            IDLE: begin
                if (bus.i_valid) begin
                    w_state_nxt = EMIT;
                    w_slot_nxt  = '0;
                    w_color_nxt = RED;
                end
            end
            EMIT: begin
                if (r_color == BLUE) begin
                    w_color_nxt = RED;
                    if (r_slot == c_last_slot) begin
                        w_slot_nxt  = '0;
                        w_state_nxt = bus.i_valid ? EMIT : IDLE;
                    end else begin
                        w_slot_nxt = r_slot + 3'd1;
                    end
                end else begin
                    w_color_nxt = color_e'(r_color + 2'd1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col         <= '0;
            r_rows_filled <= '0;
            r_row_end     <= 1'b0;
            for (int k = 0; k < KHEIGHT; k++) begin
                r_column[k] <= '0;
            end
        end else if (w_accept) begin
            // Slot k holds row r-(4-k); it is only real once that many rows exist.
            for (int k = 0; k < c_nbuf; k++) begin
                r_column[k] <= (k + int'(w_rows) >= c_nbuf) ? w_lb_rd[k] : '0;
            end
            r_column[c_nbuf] <= bus.i_pixel;
            r_row_end        <= bus.i_row_end;
            if (w_wrap) begin
                r_col         <= '0;
                r_rows_filled <= (w_rows == 3'(c_nbuf)) ? w_rows : w_rows + 3'd1;
            end else begin
                r_col         <= w_col + 1'b1;
                r_rows_filled <= w_rows;
            end
        end
    end

    assign w_byte        = color_byte(r_column[r_slot], r_color);
    assign bus.o_ready   = w_ready;
    assign bus.o_valid   = (r_state == EMIT);
    assign bus.o_pixel   = (r_state == EMIT) ? w_byte : 8'h00;
    assign bus.o_row_end = (r_state == EMIT) && w_last_byte && r_row_end;

endmodule
`default_nettype wire

// File: tb/tb_blur_column_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_blur_column_feeder
// Brief    : Directed bench with a queue-based column model and literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blur_column_feeder;
    import blur_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    blur_column_feeder_if bus();

    blur_column_feeder #(
        .IMG_WIDTH (W),
        .KHEIGHT   (5)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        chk_en  = 1'b0;
    logic        m_acc   = 1'b0;
    int          m_col   = 0;
    int          m_rf    = 0;
    logic [8:0]  exp_q [$];
    logic [8:0]  cap_q [$];
    logic [23:0] hist [W][$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: column = last four pixels seen at this column plus the new one.
    task automatic model_accept(input logic [23:0] pix, input logic re, input logic fs);
        int c, rf, d, n;
        logic [23:0] s;
        c  = fs ? 0 : m_col;
        rf = fs ? 0 : m_rf;
        for (int k = 0; k < 5; k++) begin
            d = 4 - k;
            n = hist[c].size();
            if (k == 4)                 s = pix;
            else if (d <= rf && n >= d) s = hist[c][n-d];
            else                        s = 24'h0;
            exp_q.push_back({1'b0, s[23:16]});
            exp_q.push_back({1'b0, s[15:8]});
            exp_q.push_back({(k == 4) && re, s[7:0]});
        end
        hist[c].push_back(pix);
        if (hist[c].size() > 4) void'(hist[c].pop_front());
        if (re || c == W - 1) begin
            m_col = 0;
            m_rf  = (rf + 1 > 4) ? 4 : rf + 1;
        end else begin
            m_col = c + 1;
            m_rf  = rf;
        end
    endtask

    always @(negedge clk) begin
        logic       m_ready;
        logic [8:0] e;
        if (chk_en) begin
            m_ready = (exp_q.size() <= 1);
            chk("o_ready", {31'd0, bus.o_ready}, {31'd0, m_ready});
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("o_valid", {31'd0, bus.o_valid}, 32'd1);
                chk("o_pixel", {24'd0, bus.o_pixel}, {24'd0, e[7:0]});
                chk("o_row_end", {31'd0, bus.o_row_end}, {31'd0, e[8]});
                cap_q.push_back({bus.o_row_end, bus.o_pixel});
            end else begin
                chk("o_valid_idle", {31'd0, bus.o_valid}, 32'd0);
                chk("o_row_end_idle", {31'd0, bus.o_row_end}, 32'd0);
            end
            if (rst) begin
                exp_q.delete();
                m_col = 0;
                m_rf  = 0;
                m_acc = 1'b0;
            end else if (bus.i_valid && m_ready) begin
                model_accept(bus.i_pixel, bus.i_row_end, bus.i_frame_start);
                m_acc = 1'b1;
            end else begin
                m_acc = 1'b0;
            end
        end
    end

    task automatic send(input logic [23:0] pix, input logic re, input logic fs);
        bus.i_valid       = 1'b1;
        bus.i_pixel       = pix;
        bus.i_row_end     = re;
        bus.i_frame_start = fs;
        for (int n = 0; ; n++) begin
            @(posedge clk);
            #1;
            if (m_acc) break;
            if (n >= 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: pixel 0x%06h not accepted within 100 cycles", pix);
                break;
            end
        end
    endtask

    task automatic idle_drain();
        bus.i_valid       = 1'b0;
        bus.i_row_end     = 1'b0;
        bus.i_frame_start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
    endtask

    task automatic check_cap(input string nm, input int base, input logic [7:0] e [15]);
        for (int i = 0; i < 15; i++) begin
            if (cap_q.size() > base + i)
                chk(nm, {24'd0, cap_q[base+i][7:0]}, {24'd0, e[i]});
            else
                chk({nm, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        logic [7:0] e [15];
        int         ones;
        int         pos;
        bus.i_valid       = 1'b0;
        bus.i_pixel       = '0;
        bus.i_row_end     = 1'b0;
        bus.i_frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("reset_o_ready", {31'd0, bus.o_ready}, 32'd1);
        chk("reset_o_pixel", {24'd0, bus.o_pixel}, 32'd0);
        chk("reset_o_row_end", {31'd0, bus.o_row_end}, 32'd0);
        rst = 1'b0;

        // First pixel after reset: nothing above it yet.
        cap_q.delete();
        send(24'h112233, 1'b0, 1'b0);
        idle_drain();
        e = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
        check_cap("first_pixel", 0, e);

        // Five rows of {row, col, AA}, streamed back to back, forced wrap at col 7.
        cap_q.delete();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < W; c++)
                send({8'(r), 8'(c), 8'hAA}, 1'b0, (r == 0) && (c == 0));
        idle_drain();
        chk("stream_byte_count", cap_q.size(), 32'd600);
        e = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA,
              8'h01, 8'h00, 8'hAA, 8'h02, 8'h00, 8'hAA};
        check_cap("row2_col0", 16 * 15, e);
        for (int k = 0; k < 5; k++) begin
            e[3*k]   = 8'(k);
            e[3*k+1] = 8'h03;
            e[3*k+2] = 8'hAA;
        end
        check_cap("row4_col3", 35 * 15, e);

        // Short row ending at col 5; next pixel restarts at col 0 with one row filled.
        cap_q.delete();
        send(24'h500000, 1'b0, 1'b1);
        for (int c = 1; c <= 5; c++)
            send({8'h50, 8'(c), 8'h00}, c == 5, 1'b0);
        send(24'h606060, 1'b0, 1'b0);
        idle_drain();
        ones = 0;
        pos  = -1;
        foreach (cap_q[i]) begin
            if (cap_q[i][8]) begin
                ones++;
                pos = i;
            end
        end
        chk("row_end_count", ones, 32'd1);
        chk("row_end_position", pos, 32'd89);
        e = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h50, 8'h00, 8'h00, 8'h60, 8'h60, 8'h60};
        check_cap("after_short_row", 6 * 15, e);

        // Reset in the middle of a column, then a frame-start pixel.
        cap_q.delete();
        send(24'h777777, 1'b0, 1'b0);
        bus.i_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midreset_o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("midreset_o_ready", {31'd0, bus.o_ready}, 32'd1);
        chk("midreset_bytes_seen", cap_q.size(), 32'd7);
        cap_q.delete();
        send(24'hABCDEF, 1'b0, 1'b1);
        idle_drain();
        e = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'hAB, 8'hCD, 8'hEF};
        check_cap("frame_start_after_reset", 0, e);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
